// File: rtl/mem_lsu_pkg.sv
// Shared types, constants and operation codes for the load/store unit.
// Holds the register-bus widths, the reset and enable constants, the aluop
// load/store codes, the FSM state type and small lane helpers.
package mem_lsu_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 8;

  typedef logic [REG_W-1:0]      reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [ALUOP_W-1:0]    aluop_t;

  localparam reg_bus_t  ZERO_WORD     = '0;
  localparam reg_addr_t NOP_REG_ADDR  = '0;
  localparam logic      WRITE_DISABLE = 1'b0;
  localparam logic      WRITE_ENABLE  = 1'b1;

  localparam aluop_t ALU_NOP = 8'b0000_0000;
  localparam aluop_t ALU_ADD = 8'b0010_0000;
  localparam aluop_t ALU_LB  = 8'b1110_0000;
  localparam aluop_t ALU_LBU = 8'b1110_0100;
  localparam aluop_t ALU_LH  = 8'b1110_0001;
  localparam aluop_t ALU_LHU = 8'b1110_0101;
  localparam aluop_t ALU_LW  = 8'b1110_0011;
  localparam aluop_t ALU_SB  = 8'b1110_1000;
  localparam aluop_t ALU_SH  = 8'b1110_1001;
  localparam aluop_t ALU_SW  = 8'b1110_1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  function automatic logic is_load(input aluop_t op);
    return (op == ALU_LB) || (op == ALU_LBU) || (op == ALU_LH) ||
           (op == ALU_LHU) || (op == ALU_LW);
  endfunction

  function automatic logic is_store(input aluop_t op);
    return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
  endfunction

  function automatic acc_size_e acc_size(input aluop_t op);
    case (op)
      ALU_LB, ALU_LBU, ALU_SB: return SZ_BYTE;
      ALU_LH, ALU_LHU, ALU_SH: return SZ_HALF;
      default:                 return SZ_WORD;
    endcase
  endfunction

  // Big-endian lane enables: byte offset 0 is the most significant lane.
  function automatic logic [3:0] byte_sel(input aluop_t op, input logic [1:0] off);
    case (acc_size(op))
      SZ_BYTE: begin
        case (off)
          2'd0:    return 4'b1000;
          2'd1:    return 4'b0100;
          2'd2:    return 4'b0010;
          default: return 4'b0001;
        endcase
      end
      SZ_HALF: return off[1] ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is replicated so every enabled lane carries the operand.
  function automatic reg_bus_t store_lanes(input aluop_t op, input reg_bus_t d);
    case (acc_size(op))
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_lane_ext.sv
// Picks the addressed byte/halfword out of a big-endian read word and
// sign- or zero-extends it according to the load operation.
module mem_lane_ext
  import mem_lsu_pkg::*;
(
  input  aluop_t     op,
  input  logic [1:0] byte_off,
  input  reg_bus_t   rdata,
  output reg_bus_t   ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select and extension, purely combinational.
  always_comb begin
    byte_v = rdata[7:0];
    case (byte_off)
      2'd0:    byte_v = rdata[31:24];
      2'd1:    byte_v = rdata[23:16];
      2'd2:    byte_v = rdata[15:8];
      default: byte_v = rdata[7:0];
    endcase
    half_v = byte_off[1] ? rdata[15:0] : rdata[31:16];
    case (op)
      ALU_LB:  ext = {{24{byte_v[7]}}, byte_v};
      ALU_LBU: ext = {24'h0, byte_v};
      ALU_LH:  ext = {{16{half_v[15]}}, half_v};
      ALU_LHU: ext = {16'h0, half_v};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit of the MEM stage. Non-memory results pass straight
// through; loads and stores run a three-state IDLE/WAIT/DONE sequence on
// the data bus and stall the pipeline until the result is ready.
// Optional build macro: MEM_ALIGN_CHECK_EN (abort misaligned half/word
// accesses with a bus error instead of issuing them).
//
// Data-bus handshake: mem_req_o rises on the first WAIT cycle and stays
// high, with mem_addr_o/mem_sel_o/mem_we_o/mem_data_o stable, until a cycle
// in which mem_ack_i is high; that cycle completes the transfer (read data
// is sampled on mem_data_i then) and mem_req_o drops on the next edge.
// A WAIT that sees no ack for TIMEOUT cycles is abandoned the same way.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  reg_bus_t          wdata_i,
  input  reg_addr_t         wd_i,
  input  logic              wreg_i,
  input  aluop_t            aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  reg_bus_t          reg2_i,
  input  logic              flush_i,
  output reg_bus_t          wdata_o,
  output reg_addr_t         wd_o,
  output logic              wreg_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_sel_o,
  output logic [31:0]       mem_data_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_data_i,
  output logic              stallreq_o,
  output logic              bus_err_o,
  output lsu_state_e        state_dbg
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  lsu_state_e  state;
  aluop_t      op_q;
  logic [1:0]  off_q;
  reg_addr_t   wd_q;
  logic        wreg_q;
  logic        flush_q;
  logic        err_q;
  logic [15:0] wait_cnt;
  reg_bus_t    result_q;
  reg_bus_t    load_ext;
  logic        is_mem_in;
  logic        flush_seen;
  logic        align_fault;

  assign is_mem_in  = is_load(aluop_i) || is_store(aluop_i);
  assign flush_seen = flush_q || flush_i;
  assign state_dbg  = state;

`ifdef MEM_ALIGN_CHECK_EN
  // Halfwords need addr[0]=0, words need addr[1:0]=0.
  always_comb begin
    align_fault = 1'b0;
    case (acc_size(aluop_i))
      SZ_HALF: align_fault = mem_addr_i[0];
      SZ_WORD: align_fault = |mem_addr_i[1:0];
      default: align_fault = 1'b0;
    endcase
  end
`else
  assign align_fault = 1'b0;
`endif

  mem_lane_ext u_lane_ext (
    .op       (op_q),
    .byte_off (off_q),
    .rdata    (mem_data_i),
    .ext      (load_ext)
  );

  // Access sequencer: latches the request, drives the bus and captures data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= ALU_NOP;
      off_q      <= 2'b00;
      wd_q       <= NOP_REG_ADDR;
      wreg_q     <= WRITE_DISABLE;
      flush_q    <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt   <= 16'd0;
      result_q   <= ZERO_WORD;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_sel_o  <= 4'b0000;
      mem_data_o <= 32'h0;
      bus_err_o  <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (is_mem_in && !flush_i) begin
            op_q     <= aluop_i;
            off_q    <= mem_addr_i[1:0];
            wd_q     <= wd_i;
            wreg_q   <= wreg_i;
            flush_q  <= 1'b0;
            wait_cnt <= 16'd0;
            result_q <= ZERO_WORD;
            if (align_fault) begin
              err_q     <= 1'b1;
              bus_err_o <= 1'b1;
              state     <= ST_DONE;
            end else begin
              err_q      <= 1'b0;
              mem_req_o  <= 1'b1;
              mem_we_o   <= is_store(aluop_i);
              mem_addr_o <= {mem_addr_i[ADDR_W-1:2], 2'b00};
              mem_sel_o  <= byte_sel(aluop_i, mem_addr_i[1:0]);
              mem_data_o <= is_store(aluop_i) ? store_lanes(aluop_i, reg2_i) : 32'h0;
              state      <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (flush_i) flush_q <= 1'b1;
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            mem_sel_o <= 4'b0000;
            result_q  <= load_ext;
            state     <= flush_seen ? ST_IDLE : ST_DONE;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            mem_sel_o <= 4'b0000;
            wait_cnt  <= wait_cnt + 16'd1;
            if (flush_seen) begin
              state <= ST_IDLE;
            end else begin
              err_q     <= 1'b1;
              bus_err_o <= 1'b1;
              state     <= ST_DONE;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Write-back and stall outputs; reset forces the no-write defaults.
  always_comb begin
    wdata_o    = ZERO_WORD;
    wd_o       = NOP_REG_ADDR;
    wreg_o     = WRITE_DISABLE;
    stallreq_o = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (is_mem_in) begin
            stallreq_o = !flush_i;
          end else begin
            wdata_o = wdata_i;
            wd_o    = wd_i;
            wreg_o  = wreg_i;
          end
        end
        ST_WAIT: begin
          stallreq_o = 1'b1;
        end
        ST_DONE: begin
          wdata_o = result_q;
          wd_o    = wd_q;
          wreg_o  = wreg_q && is_load(op_q) && !err_q && !flush_i;
        end
        default: begin
          stallreq_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu (TIMEOUT=4): directed bus scenarios,
// random load/store traffic through a result queue, flush/reset/timeout.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  reg_bus_t          wdata_i;
  reg_addr_t         wd_i;
  logic              wreg_i;
  aluop_t            aluop_i;
  logic [ADDR_W-1:0] mem_addr_i;
  reg_bus_t          reg2_i;
  logic              flush_i;
  reg_bus_t          wdata_o;
  reg_addr_t         wd_o;
  logic              wreg_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0]        mem_sel_o;
  logic [31:0]       mem_data_o;
  logic              mem_ack_i;
  logic [31:0]       mem_data_i;
  logic              stallreq_o;
  logic              bus_err_o;
  lsu_state_e        state_dbg;

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  aluop_t mem_ops[8] = '{ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW, ALU_SB, ALU_SH, ALU_SW};

  mem_lsu #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wdata_i(wdata_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .flush_i(flush_i),
    .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog against a hung run
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aluop_i    = ALU_NOP;
    wdata_i    = 32'h0;
    wd_i       = 5'd0;
    wreg_i     = 1'b0;
    mem_addr_i = 32'h0;
    reg2_i     = 32'h0;
    flush_i    = 1'b0;
    mem_ack_i  = 1'b0;
    mem_data_i = 32'h0;
  endtask

  // Reference model
  function automatic logic m_is_load(input aluop_t op);
    return op == ALU_LB || op == ALU_LBU || op == ALU_LH || op == ALU_LHU || op == ALU_LW;
  endfunction

  function automatic logic [3:0] m_sel(input aluop_t op, input logic [1:0] a);
    if (op == ALU_LB || op == ALU_LBU || op == ALU_SB) return 4'b1000 >> a;
    if (op == ALU_LH || op == ALU_LHU || op == ALU_SH) return a[1] ? 4'b0011 : 4'b1100;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_load(input aluop_t op, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * (3 - 32'(a)))) & 32'h0000_00FF;
    h = (d >> (a[1] ? 0 : 16)) & 32'h0000_FFFF;
    case (op)
      ALU_LB:  return b[7] ? (b | 32'hFFFF_FF00) : b;
      ALU_LBU: return b;
      ALU_LH:  return h[15] ? (h | 32'hFFFF_0000) : h;
      ALU_LHU: return h;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input aluop_t op, input logic [31:0] d);
    if (op == ALU_SB) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (op == ALU_SH) return {d[15:0], d[15:0]};
    return d;
  endfunction

  // Full access: accept, WAIT for ack_lat+1 cycles (ack in the last), DONE, IDLE.
  task automatic do_access(input aluop_t op, input logic [31:0] addr, input logic [31:0] st,
                           input int ack_lat, input logic [31:0] rdata, input logic flush_done);
    logic      ld;
    reg_addr_t wd;
    ld = m_is_load(op);
    wd = 5'($urandom_range(1, 31));
    aluop_i = op; mem_addr_i = addr; reg2_i = st; wd_i = wd; wreg_i = 1'b1;
    wdata_i = $urandom; flush_i = 1'b0;
    #1;
    check("acc_stall", 32'(stallreq_o), 32'd1);
    check("acc_req", 32'(mem_req_o), 32'd0);
    check("acc_wreg", 32'(wreg_o), 32'd0);
    if (ld) exp_q.push_back(m_load(op, addr[1:0], rdata));
    tick();
    idle_inputs();
    mem_addr_i = $urandom; reg2_i = $urandom;
    for (int i = 0; i <= ack_lat; i++) begin
      if (i == ack_lat) begin
        mem_ack_i = 1'b1;
        mem_data_i = rdata;
      end
      #1;
      check("wait_req", 32'(mem_req_o), 32'd1);
      check("wait_we", 32'(mem_we_o), 32'(!ld));
      check("wait_sel", 32'(mem_sel_o), 32'(m_sel(op, addr[1:0])));
      check("wait_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
      if (!ld) check("wait_data", mem_data_o, m_store(op, st));
      check("wait_stall", 32'(stallreq_o), 32'd1);
      check("wait_err", 32'(bus_err_o), 32'd0);
      tick();
    end
    mem_ack_i = 1'b0; mem_data_i = $urandom; flush_i = flush_done;
    #1;
    check("done_state", 32'(state_dbg), 32'(ST_DONE));
    check("done_stall", 32'(stallreq_o), 32'd0);
    check("done_req", 32'(mem_req_o), 32'd0);
    check("done_sel", 32'(mem_sel_o), 32'd0);
    check("done_we", 32'(mem_we_o), 32'd0);
    check("done_err", 32'(bus_err_o), 32'd0);
    check("done_wd", 32'(wd_o), 32'(wd));
    check("done_wreg", 32'(wreg_o), 32'(ld && !flush_done));
    if (ld) begin
      check("sb_size", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) check("done_wdata", wdata_o, exp_q.pop_front());
    end
    tick();
    flush_i = 1'b0;
    #1;
    check("back_idle", 32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    idle_inputs();
    // Reset with non-memory traffic on the inputs: outputs must be forced
    rst = 1'b1;
    aluop_i = ALU_ADD; wdata_i = 32'h55; wd_i = 5'd4; wreg_i = 1'b1;
    repeat (3) tick();
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_we", 32'(mem_we_o), 32'd0);
    check("rst_sel", 32'(mem_sel_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_mdata", mem_data_o, 32'd0);
    check("rst_err", 32'(bus_err_o), 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_wd", 32'(wd_o), 32'd0);
    check("rst_wreg", 32'(wreg_o), 32'd0);
    check("rst_stall", 32'(stallreq_o), 32'd0);
    rst = 1'b0;
    idle_inputs();
    tick();

    // Zero-latency pass-through of non-memory results
    for (int i = 0; i < 4; i++) begin
      logic [31:0] wv;
      reg_addr_t   wdv;
      logic        we;
      wv = $urandom; wdv = 5'($urandom_range(0, 31)); we = 1'($urandom_range(0, 1));
      aluop_i = ALU_ADD; wdata_i = wv; wd_i = wdv; wreg_i = we;
      #1;
      check("pass_wdata", wdata_o, wv);
      check("pass_wd", 32'(wd_o), 32'(wdv));
      check("pass_wreg", 32'(wreg_o), 32'(we));
      check("pass_stall", 32'(stallreq_o), 32'd0);
      tick();
    end
    idle_inputs();

    // Directed accesses
    do_access(ALU_LW, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    do_access(ALU_LB, 32'h103, 32'h0, 0, 32'h0000_00F0, 1'b0);
    do_access(ALU_LBU, 32'h103, 32'h0, 1, 32'h0000_00F0, 1'b0);
    do_access(ALU_SH, 32'h102, 32'h1234ABCD, 0, 32'h0, 1'b0);
    do_access(ALU_LHU, 32'h200, 32'h0, 2, 32'h8765_4321, 1'b1);

    // Random traffic, including misaligned half/word addresses
    for (int n = 0; n < 24; n++) begin
      do_access(mem_ops[$urandom_range(0, 7)], $urandom & 32'h0000_0FFF, $urandom,
                int'($urandom_range(0, TIMEOUT - 1)), $urandom, 1'($urandom_range(0, 5) == 0));
    end

    // Timeout: no ack for TIMEOUT WAIT cycles
    aluop_i = ALU_LW; mem_addr_i = 32'h300; wd_i = 5'd9; wreg_i = 1'b1;
    #1;
    tick();
    idle_inputs();
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      check("to_req", 32'(mem_req_o), 32'd1);
      check("to_err_early", 32'(bus_err_o), 32'd0);
      tick();
    end
    check("to_err", 32'(bus_err_o), 32'd1);
    check("to_state", 32'(state_dbg), 32'(ST_DONE));
    check("to_wreg", 32'(wreg_o), 32'd0);
    check("to_req_off", 32'(mem_req_o), 32'd0);
    check("to_stall", 32'(stallreq_o), 32'd0);
    tick();
    check("to_err_pulse", 32'(bus_err_o), 32'd0);
    check("to_idle", 32'(state_dbg), 32'(ST_IDLE));

    // Flush pulse in WAIT, ack three cycles later
    aluop_i = ALU_LW; mem_addr_i = 32'h400; wd_i = 5'd3; wreg_i = 1'b1;
    #1;
    tick();
    idle_inputs();
    flush_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_ack_i = 1'b1;
        mem_data_i = 32'hCAFE_F00D;
      end
      #1;
      check("fl_req", 32'(mem_req_o), 32'd1);
      check("fl_err_wait", 32'(bus_err_o), 32'd0);
      tick();
      flush_i = 1'b0;
    end
    mem_ack_i = 1'b0;
    #1;
    check("fl_state", 32'(state_dbg), 32'(ST_IDLE));
    check("fl_req_off", 32'(mem_req_o), 32'd0);
    check("fl_err", 32'(bus_err_o), 32'd0);
    check("fl_wreg", 32'(wreg_o), 32'd0);
    tick();
    check("fl_err_late", 32'(bus_err_o), 32'd0);

    // Flush in IDLE does not start an access
    aluop_i = ALU_LW; mem_addr_i = 32'h500; flush_i = 1'b1; wreg_i = 1'b1;
    #1;
    check("fi_stall", 32'(stallreq_o), 32'd0);
    tick();
    check("fi_state", 32'(state_dbg), 32'(ST_IDLE));
    check("fi_req", 32'(mem_req_o), 32'd0);
    idle_inputs();

    // Reset in WAIT, then zero-latency ADD and an ignored late ack
    aluop_i = ALU_LW; mem_addr_i = 32'h600; wd_i = 5'd2; wreg_i = 1'b1;
    #1;
    tick();
    idle_inputs();
    #1;
    check("rw_req_on", 32'(mem_req_o), 32'd1);
    rst = 1'b1;
    aluop_i = ALU_ADD; wdata_i = 32'd5; wd_i = 5'd3; wreg_i = 1'b1;
    #1;
    check("rw_wdata", wdata_o, 32'd0);
    check("rw_wreg", 32'(wreg_o), 32'd0);
    check("rw_stall", 32'(stallreq_o), 32'd0);
    tick();
    check("rw_req", 32'(mem_req_o), 32'd0);
    check("rw_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;
    #1;
    check("rw_add", wdata_o, 32'd5);
    check("rw_add_wreg", 32'(wreg_o), 32'd1);
    check("rw_add_stall", 32'(stallreq_o), 32'd0);
    tick();
    idle_inputs();
    mem_ack_i = 1'b1; mem_data_i = 32'hFFFF_FFFF;
    tick();
    check("late_state", 32'(state_dbg), 32'(ST_IDLE));
    check("late_req", 32'(mem_req_o), 32'd0);
    check("late_err", 32'(bus_err_o), 32'd0);
    idle_inputs();
    tick();

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
